// File: rtl/lcd_value_formatter.sv
// Formats a 16-bit value as right-aligned decimal ASCII and hands double-buffered rows to the LCD1602 driver.
// Optional LCD_FMT_HEX_EN appends "0x" plus four hex digits in chars 10..15 of row 2.
module lcd_value_formatter #(
  parameter logic [127:0] ROW1_TEXT   = "VALUE:          ",
  parameter int unsigned  ACK_TIMEOUT = 200_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         value_valid,
  input  logic [15:0]  value,
  input  logic         no_busy,
  output logic [127:0] row_1,
  output logic [127:0] row_2,
  output logic         start_show,
  output logic         fmt_busy
);

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT_READY, WAIT_ACK} state_t;

  state_t        state, state_next;
  logic [3:0]    iter;
  logic [23:0]   timer;
  logic          pending, pending_next;
  logic [15:0]   pend_val;
  logic [15:0]   shift_reg;
  logic [19:0]   bcd, bcd_next;
  logic [127:0]  staging;
  logic          start_conv, commit;
  logic [15:0]   conv_src;
`ifdef LCD_FMT_HEX_EN
  logic [15:0]   val_lat;
`endif

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [19:0] dd_step(input logic [19:0] b, input logic in);
    logic [19:0] a;
    a = b;
    for (int i = 0; i < 5; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a[18:0], in};
  endfunction

  // Five ASCII digits with leading zeros blanked; the units digit always shows.
  function automatic logic [39:0] dec_field(input logic [19:0] b);
    logic [39:0] f;
    logic        lead;
    lead = 1'b1;
    f    = '0;
    for (int i = 4; i >= 0; i--) begin
      if (lead && b[4*i +: 4] == 4'd0 && i != 0) begin
        f[8*i +: 8] = 8'h20;
      end else begin
        f[8*i +: 8] = {4'h3, b[4*i +: 4]};
        lead = 1'b0;
      end
    end
    return f;
  endfunction

`ifdef LCD_FMT_HEX_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
`endif

  assign bcd_next   = dd_step(bcd, shift_reg[15]);
  assign start_conv = (state == IDLE) && (value_valid || pending);
  assign conv_src   = value_valid ? value : pend_val;
  assign commit     = (state == WAIT_READY) && no_busy;

  always_comb begin
    state_next   = state;
    pending_next = (state == IDLE) ? 1'b0 : (pending | value_valid);
    case (state)
      IDLE:       if (value_valid || pending) state_next = CONVERT;
      CONVERT:    if (iter == 4'd15) state_next = WAIT_READY;
      WAIT_READY: if (no_busy) state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (!no_busy)                              state_next = IDLE;
        else if (timer == 24'(ACK_TIMEOUT - 1))    state_next = WAIT_READY;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter       <= '0;
      timer      <= '0;
      pending    <= 1'b0;
      start_show <= 1'b0;
      fmt_busy   <= 1'b0;
      row_1      <= ROW1_TEXT;
      row_2      <= {16{8'h20}};
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      fmt_busy   <= (state_next != IDLE) || pending_next;
      iter       <= (state == CONVERT) ? iter + 4'd1 : 4'd0;
      timer      <= (state == WAIT_ACK) ? timer + 24'd1 : 24'd0;
      start_show <= commit;
      // Rows only move on the commit edge, so the driver never sees them change mid-write.
      if (commit) begin
        row_1 <= ROW1_TEXT;
        row_2 <= staging;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_conv) begin
      shift_reg <= conv_src;
      bcd       <= '0;
`ifdef LCD_FMT_HEX_EN
      val_lat   <= conv_src;
`endif
    end else if (state == CONVERT) begin
      shift_reg <= {shift_reg[14:0], 1'b0};
      bcd       <= bcd_next;
      if (iter == 4'd15) begin
`ifdef LCD_FMT_HEX_EN
        staging <= {dec_field(bcd_next), {5{8'h20}}, 16'h3078,
                    hex_char(val_lat[15:12]), hex_char(val_lat[11:8]),
                    hex_char(val_lat[7:4]), hex_char(val_lat[3:0])};
`else
        staging <= {dec_field(bcd_next), {11{8'h20}}};
`endif
      end
    end
    if (state != IDLE && value_valid) pend_val <= value;
  end

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Scoreboard bench for lcd_value_formatter: expected refreshes are queued with stimulus and checked on each start_show.
module tb_lcd_value_formatter;

  localparam logic [127:0] ROW1  = "VALUE:          ";
  localparam logic [127:0] BLANK = {16{8'h20}};
`ifdef LCD_FMT_HEX_EN
  localparam bit HEX_ON = 1'b1;
`else
  localparam bit HEX_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         value_valid = 1'b0;
  logic [15:0]  value = '0;
  logic         no_busy;
  logic [127:0] row_1, row_2;
  logic         start_show, fmt_busy;

  logic auto_ack  = 1'b0;
  logic manual_nb = 1'b1;
  logic model_nb  = 1'b1;
  int   busy_cnt  = 0;
  assign no_busy = auto_ack ? model_nb : manual_nb;

  int   tests_run = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   pulse_cnt = 0;
  logic prev_ss   = 1'b0;

  typedef struct {
    logic [127:0] r2;
    int           at;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  lcd_value_formatter #(.ROW1_TEXT("VALUE:          "), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .value_valid(value_valid), .value(value),
    .no_busy(no_busy), .row_1(row_1), .row_2(row_2),
    .start_show(start_show), .fmt_busy(fmt_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver model: accepts a refresh one cycle after start_show, stays busy three cycles.
  always @(negedge clk) begin
    if (!auto_ack) begin
      model_nb = 1'b1;
      busy_cnt = 0;
    end else if (start_show) begin
      model_nb = 1'b0;
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_nb = 1'b1;
    end
  end

  // Monitor: every start_show pulse must match the oldest queued refresh.
  always @(negedge clk) begin
    if (rst_n && start_show) begin
      pulse_cnt++;
      tests_run++;
      if (prev_ss) begin
        fails++;
        $display("FAIL pulse_width: start_show high on consecutive cycles at cycle %0d, required one cycle", cyc);
      end
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_refresh: start_show at cycle %0d with row_2=\"%s\", required no refresh", cyc, row_2);
      end else begin
        e = sb.pop_front();
        if (row_1 !== ROW1 || row_2 !== e.r2 || (e.at >= 0 && cyc != e.at)) begin
          fails++;
          $display("FAIL refresh: got row_1=\"%s\" row_2=\"%s\" cycle %0d, required row_1=\"%s\" row_2=\"%s\" cycle %0d",
                   row_1, row_2, cyc, ROW1, e.r2, e.at);
        end
      end
    end
    prev_ss = start_show;
  end

  function automatic logic [127:0] mk_row2(input logic [39:0] dec, input logic [47:0] hx);
    return {dec, {5{8'h20}}, HEX_ON ? hx : {6{8'h20}}};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [127:0] r2, input int at);
    exp_t x;
    x.r2 = r2;
    x.at = at;
    sb.push_back(x);
  endtask

  task automatic strobe(input logic [15:0] v);
    value       = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL %s: %0d refresh(es) outstanding after %0d cycles, required 0", nm, sb.size(), limit);
      sb.delete();
    end
  endtask

  logic [15:0] vals [4] = '{16'd12345, 16'd0, 16'd65535, 16'd42};
  logic [39:0] decs [4] = '{"12345", "    0", "65535", "   42"};
  logic [47:0] hexs [4] = '{"0x3039", "0x0000", "0xFFFF", "0x002A"};

  initial begin
    int pc;
    // Reset values
    repeat (3) @(negedge clk);
    check("reset_row_1", row_1, ROW1);
    check("reset_row_2", row_2, BLANK);
    check("reset_start_show", {127'b0, start_show}, 128'd0);
    check("reset_fmt_busy", {127'b0, fmt_busy}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed conversions with the driver idle: fixed 17-cycle latency
    auto_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      strobe(vals[i]);
      check("busy_after_strobe", {127'b0, fmt_busy}, 128'd1);
      push(mk_row2(decs[i], hexs[i]), cyc + 17);
      wait_drain("conversion", 60);
      repeat (8) @(negedge clk);
      check("idle_fmt_busy", {127'b0, fmt_busy}, 128'd0);
      check("row_2_held", row_2, mk_row2(decs[i], hexs[i]));
    end

    // Driver busy: no refresh and rows frozen until no_busy rises
    auto_ack  = 1'b0;
    manual_nb = 1'b0;
    @(negedge clk);
    pc = pulse_cnt;
    strobe(16'd7);
    repeat (1000) @(negedge clk);
    check("no_pulse_while_busy", 128'(pulse_cnt), 128'(pc));
    check("rows_frozen", row_2, mk_row2("   42", "0x002A"));
    check("busy_waiting", {127'b0, fmt_busy}, 128'd1);
    push(mk_row2("    7", "0x0007"), cyc + 1);
    manual_nb = 1'b1;
    wait_drain("ready_release", 5);
    manual_nb = 1'b0;
    repeat (3) @(negedge clk);
    manual_nb = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", {127'b0, fmt_busy}, 128'd0);

    // Strobes during WAIT_ACK: latest value wins, then ack timeout re-pulses
    strobe(16'd5);
    push(mk_row2("    5", "0x0005"), cyc + 17);
    wait_drain("pending_first", 60);
    strobe(16'd100);
    strobe(16'd200);
    manual_nb = 1'b0;
    @(negedge clk);
    check("pending_busy", {127'b0, fmt_busy}, 128'd1);
    manual_nb = 1'b1;
    push(mk_row2("  200", "0x00C8"), -1);
    wait_drain("pending_latest", 60);
    push(mk_row2("  200", "0x00C8"), cyc + 9);
    wait_drain("ack_timeout", 20);
    manual_nb = 1'b0;
    repeat (3) @(negedge clk);
    manual_nb = 1'b1;
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion
    auto_ack = 1'b1;
    strobe(16'd999);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_row_1", row_1, ROW1);
    check("midreset_row_2", row_2, BLANK);
    check("midreset_start_show", {127'b0, start_show}, 128'd0);
    check("midreset_fmt_busy", {127'b0, fmt_busy}, 128'd0);
    pc = pulse_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_pulse_after_reset", 128'(pulse_cnt), 128'(pc));
    check("row_2_after_reset", row_2, BLANK);
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
